// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic blocks: digit width, FSM encoding
// and the digit-validity helper.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } bcd_state_e;

    function automatic logic digit_valid(input logic [BCD_DIGIT_W-1:0] d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_adder_ndigit.sv
// Combinational ripple of single-digit BCD adders over N_DIG packed digits.
module bcd_adder_ndigit
    import bcd_pkg::*;
#(
    parameter int N_DIG = 8
) (
    input  logic [BCD_DIGIT_W*N_DIG-1:0] a,
    input  logic [BCD_DIGIT_W*N_DIG-1:0] b,
    input  logic                         cin,
    output logic [BCD_DIGIT_W*N_DIG-1:0] sum,
    output logic                         cout
);

    logic [N_DIG:0] carry;

    assign carry[0] = cin;
    assign cout     = carry[N_DIG];

    for (genvar g = 0; g < N_DIG; g++) begin : g_digit
        logic [4:0] raw;

        assign raw = {1'b0, a[g*BCD_DIGIT_W +: BCD_DIGIT_W]}
                   + {1'b0, b[g*BCD_DIGIT_W +: BCD_DIGIT_W]}
                   + {4'd0, carry[g]};
        assign carry[g+1] = (raw > 5'd9);
        // +6 wraps the low nibble back into 0..9 when the digit overflows
        assign sum[g*BCD_DIGIT_W +: BCD_DIGIT_W] = carry[g+1] ? (raw[3:0] + 4'd6) : raw[3:0];
    end

endmodule

// File: rtl/bcd_multiplier.sv
// Sequential packed-BCD multiplier using digit-serial repeated addition;
// start/end handshake matches the repeated-subtraction BCD divider.
//
// state | meaning
// IDLE  | waiting for start; operands sampled here
// CALC  | one add, shift or finish decision per cycle
// DONE  | one-cycle completion pulse, then back to IDLE
module bcd_multiplier
    import bcd_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] multiplicand,
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] multiplier,
    output logic [2*BCD_DIGIT_W*N_DIGITS-1:0] product,
    output logic                            busy,
    output logic                            end_multiplication,
    output logic                            err
);

    localparam int OP_W   = BCD_DIGIT_W * N_DIGITS;
    localparam int PROD_W = 2 * OP_W;
    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    bcd_state_e        state_q,   state_d;
    logic [PROD_W-1:0] product_q, product_d;
    logic [PROD_W-1:0] mcand_q,   mcand_d;
    logic [OP_W-1:0]   mplier_q,  mplier_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic              err_q,     err_d;

    logic [PROD_W-1:0] add_sum;
    logic              cout_unused;
    logic              ops_valid;

    bcd_adder_ndigit #(
        .N_DIG(2 * N_DIGITS)
    ) u_adder (
        .a   (product_q),
        .b   (mcand_q),
        .cin (1'b0),
        .sum (add_sum),
        .cout(cout_unused)
    );

    always_comb begin
        ops_valid = 1'b1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!digit_valid(multiplicand[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
                !digit_valid(multiplier[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
                ops_valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            product_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            product_q <= product_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        product_d = product_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        idx_d     = idx_q;
        err_d     = err_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    product_d = '0;
                    if (ops_valid) begin
                        mcand_d  = {{OP_W{1'b0}}, multiplicand};
                        mplier_d = multiplier;
                        idx_d    = '0;
                        err_d    = 1'b0;
                        state_d  = CALC;
                    end else begin
                        err_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            CALC: begin
                if (mplier_q[BCD_DIGIT_W-1:0] != '0) begin
                    product_d = add_sum;
                    mplier_d[BCD_DIGIT_W-1:0] = mplier_q[BCD_DIGIT_W-1:0] - 4'd1;
                end else if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    mplier_d = mplier_q >> BCD_DIGIT_W;
                    mcand_d  = mcand_q << BCD_DIGIT_W;
                    idx_d    = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product            = product_q;
    assign err                = err_q;
    assign busy               = (state_q != IDLE);
    assign end_multiplication = (state_q == DONE);

endmodule

// File: tb/tb_bcd_multiplier.sv
// Self-checking bench for bcd_multiplier: directed table, handshake corner
// sequences and randomized operands against an integer-arithmetic model.
module tb_bcd_multiplier;

    localparam int N = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] multiplicand;
    logic [15:0] multiplier;
    logic [31:0] product;
    logic        busy;
    logic        end_multiplication;
    logic        err;

    int checks;
    int errors;

    bcd_multiplier #(.N_DIGITS(N)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .multiplicand      (multiplicand),
        .multiplier        (multiplier),
        .product           (product),
        .busy              (busy),
        .end_multiplication(end_multiplication),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mc;
        logic [15:0] mp;
        logic [31:0] prod;
        logic        err;
        int          lat;
    } vec_t;

    // ---------------- reference model ----------------
    function automatic bit m_valid(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < N; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic longint m_bcd2int(input logic [15:0] v);
        longint r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] m_int2bcd(input longint x);
        logic [31:0] r = '0;
        longint      t = x;
        for (int i = 0; i < 2 * N; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic int m_latency(input logic [15:0] a, input logic [15:0] b);
        int s = 0;
        if (!m_valid(a, b)) return 0;
        for (int i = 0; i < N; i++) s += int'(b[4*i +: 4]);
        return s + N;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Caller is #1 after a posedge with the DUT in IDLE; returns the same way.
    task automatic run_op(input logic [15:0] mc, input logic [15:0] mp,
                          input logic [31:0] ep, input logic ee, input int el,
                          input string nm);
        int n;
        int busy_bad;
        bit seen;
        multiplicand = mc;
        multiplier   = mp;
        start        = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        n        = 0;
        busy_bad = 0;
        seen     = end_multiplication;
        while (!seen && n < 64) begin
            if (busy !== 1'b1) busy_bad++;
            @(posedge clk); #1;
            n++;
            seen = end_multiplication;
        end
        chk({nm, "_pulse_seen"}, 64'(seen), 64'd1);
        chk({nm, "_latency"}, 64'(n), 64'(el));
        chk({nm, "_busy_during_op"}, 64'(busy_bad), 64'd0);
        chk({nm, "_busy_in_done"}, 64'(busy), 64'd1);
        chk({nm, "_product"}, 64'(product), 64'(ep));
        chk({nm, "_err"}, 64'(err), 64'(ee));
        @(posedge clk); #1;
        chk({nm, "_pulse_one_cycle"}, 64'(end_multiplication), 64'd0);
        chk({nm, "_idle_after"}, 64'(busy), 64'd0);
        chk({nm, "_product_held"}, 64'(product), 64'(ep));
    endtask

    vec_t vecs[10];

    initial begin
        int pulses;
        int first_pulse;
        int second_pulse;
        logic [15:0] rmc;
        logic [15:0] rmp;

        checks = 0;
        errors = 0;
        rst = 1'b0;
        start = 1'b0;
        multiplicand = '0;
        multiplier = '0;

        #12;
        chk("reset_product", 64'(product), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_end", 64'(end_multiplication), 64'd0);
        chk("reset_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_hold_busy", 64'(busy), 64'd0);

        vecs[0] = '{16'h1234, 16'h5678, 32'h07006652, 1'b0, 30};
        vecs[1] = '{16'h9999, 16'h9999, 32'h99980001, 1'b0, 40};
        vecs[2] = '{16'h0000, 16'h0000, 32'h00000000, 1'b0, 4};
        vecs[3] = '{16'h0007, 16'h0000, 32'h00000000, 1'b0, 4};
        vecs[4] = '{16'h0000, 16'h0003, 32'h00000000, 1'b0, 7};
        vecs[5] = '{16'h12A4, 16'h0001, 32'h00000000, 1'b1, 0};
        vecs[6] = '{16'h0002, 16'h0003, 32'h00000006, 1'b0, 7};
        vecs[7] = '{16'h0099, 16'h0099, 32'h00009801, 1'b0, 22};
        vecs[8] = '{16'h0001, 16'hF000, 32'h00000000, 1'b1, 0};
        vecs[9] = '{16'h5000, 16'h2000, 32'h10000000, 1'b0, 6};
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].mc, vecs[i].mp, vecs[i].prod, vecs[i].err, vecs[i].lat,
                   $sformatf("vec%0d", i));
        end

        // start re-pulsed while busy and operands changed mid-run
        multiplicand = 16'h0025;
        multiplier   = 16'h0004;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        multiplicand = 16'h9999;
        multiplier   = 16'h9999;
        pulses = 0;
        first_pulse = -1;
        for (int n = 1; n <= 20; n++) begin
            start = (n == 1 || n == 4);
            @(posedge clk); #1;
            start = 1'b0;
            if (end_multiplication) begin
                pulses++;
                if (first_pulse < 0) first_pulse = n;
            end
        end
        chk("busy_start_pulses", 64'(pulses), 64'd1);
        chk("busy_start_latency", 64'(first_pulse), 64'd8);
        chk("busy_start_product", 64'(product), 64'h100);
        chk("busy_start_idle", 64'(busy), 64'd0);

        // start held high through DONE is accepted by the following IDLE cycle
        multiplicand = 16'h0003;
        multiplier   = 16'h0002;
        start        = 1'b1;
        @(posedge clk); #1;
        pulses = 0;
        first_pulse = -1;
        second_pulse = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (n == 9) start = 1'b0;
            if (end_multiplication) begin
                pulses++;
                if (first_pulse < 0) first_pulse = n;
                else if (second_pulse < 0) second_pulse = n;
            end
        end
        chk("held_start_pulses", 64'(pulses), 64'd2);
        chk("held_start_first", 64'(first_pulse), 64'd6);
        chk("held_start_second", 64'(second_pulse), 64'd14);
        chk("held_start_product", 64'(product), 64'h6);

        // asynchronous reset mid-CALC
        multiplicand = 16'h4321;
        multiplier   = 16'h1111;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midreset_product", 64'(product), 64'd0);
        chk("midreset_busy", 64'(busy), 64'd0);
        chk("midreset_end", 64'(end_multiplication), 64'd0);
        chk("midreset_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (end_multiplication) pulses++;
        end
        chk("midreset_no_pulse", 64'(pulses), 64'd0);
        run_op(16'h0011, 16'h0011, 32'h00000121, 1'b0, 6, "after_reset");

        // randomized operands against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            for (int d = 0; d < N; d++) begin
                rmc[4*d +: 4] = 4'($urandom_range(0, 9));
                rmp[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 7) == 0) rmc[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rmp[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            run_op(rmc, rmp,
                   m_valid(rmc, rmp) ? m_int2bcd(m_bcd2int(rmc) * m_bcd2int(rmp)) : 32'h0,
                   !m_valid(rmc, rmp), m_latency(rmc, rmp),
                   $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
